// File: rtl/eth_deframer.sv
// Ethernet receive deframer: strips preamble/SFD/header, forwards payload without FCS, checks CRC-32 and runt length.
// Optional destination filter enabled by defining ETH_DEFRAMER_DST_FILTER_EN.
module eth_deframer #(
  parameter int MIN_PREAMBLE  = 1,
  parameter int CHECK_MIN_LEN = 1
) (
  input  logic        clk,
  input  logic        areset,
  output logic        in_axis_tready,
  input  logic        in_axis_tvalid,
  input  logic        in_axis_tlast,
  input  logic [7:0]  in_axis_tdata,
  input  logic        payload_axis_tready,
  output logic        payload_axis_tvalid,
  output logic        payload_axis_tlast,
  output logic [7:0]  payload_axis_tdata,
  output logic        payload_axis_tuser,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        hdr_valid,
  output logic        stat_good,
  output logic        stat_crc_err,
  output logic        stat_fmt_err,
  input  logic [47:0] local_mac
);

  typedef enum logic [1:0] {ST_PREAMBLE, ST_HEADER, ST_PAYLOAD, ST_DROP} state_t;

  localparam logic [7:0]  MIN_PRE     = 8'(MIN_PREAMBLE);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t      state;
  logic [7:0]  pre_cnt;
  logic [3:0]  hdr_cnt;
  logic [31:0] dly_buf;
  logic [2:0]  dly_cnt;
  logic [31:0] crc;
  logic [10:0] len_cnt;
  logic        drop_quiet;

  logic        buf_full;
  logic        in_fire;
  logic        dst_ok;
  logic        frame_bad;
  logic [31:0] crc_next;
  logic [10:0] len_next;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

`ifdef ETH_DEFRAMER_DST_FILTER_EN
  assign dst_ok = (dst_mac == local_mac) || (dst_mac == 48'hFFFFFFFFFFFF);
`else
  logic unused_local_mac;
  assign unused_local_mac = ^local_mac;
  assign dst_ok = 1'b1;
`endif

  // Once four bytes are held, the input and output handshakes are joined combinationally
  assign buf_full            = (state == ST_PAYLOAD) && (dly_cnt == 3'd4);
  assign in_axis_tready      = buf_full ? payload_axis_tready : 1'b1;
  assign in_fire             = in_axis_tvalid && in_axis_tready;
  assign crc_next            = crc32_byte(crc, in_axis_tdata);
  assign len_next            = sat_inc11(len_cnt);
  assign frame_bad           = (crc_next != CRC_RESIDUE) ||
                               ((CHECK_MIN_LEN != 0) && (len_next < 11'd64));
  assign payload_axis_tvalid = buf_full && in_axis_tvalid;
  assign payload_axis_tdata  = dly_buf[31:24];
  assign payload_axis_tlast  = buf_full && in_axis_tlast;
  assign payload_axis_tuser  = buf_full && in_axis_tlast && frame_bad;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= ST_PREAMBLE;
      pre_cnt      <= '0;
      hdr_cnt      <= '0;
      dly_buf      <= '0;
      dly_cnt      <= '0;
      crc          <= '1;
      len_cnt      <= '0;
      drop_quiet   <= 1'b0;
      dst_mac      <= '0;
      src_mac      <= '0;
      ethertype    <= '0;
      hdr_valid    <= 1'b0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_fmt_err <= 1'b0;
    end else begin
      hdr_valid    <= 1'b0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_fmt_err <= 1'b0;
      if (in_fire) begin
        case (state)
          ST_PREAMBLE: begin
            if (in_axis_tlast) begin
              stat_fmt_err <= 1'b1;
              pre_cnt      <= '0;
            end else if (in_axis_tdata == 8'h55) begin
              if (pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
            end else if ((in_axis_tdata == 8'hD5) && (pre_cnt >= MIN_PRE)) begin
              state   <= ST_HEADER;
              pre_cnt <= '0;
              hdr_cnt <= '0;
              crc     <= '1;
              len_cnt <= '0;
              dly_cnt <= '0;
            end else begin
              state   <= ST_DROP;
              pre_cnt <= '0;
            end
          end
          ST_HEADER: begin
            crc     <= crc_next;
            len_cnt <= len_next;
            hdr_cnt <= hdr_cnt + 4'd1;
            if (hdr_cnt < 4'd6)       dst_mac   <= {dst_mac[39:0], in_axis_tdata};
            else if (hdr_cnt < 4'd12) src_mac   <= {src_mac[39:0], in_axis_tdata};
            else                      ethertype <= {ethertype[7:0], in_axis_tdata};
            if (in_axis_tlast) begin
              stat_fmt_err <= 1'b1;
              state        <= ST_PREAMBLE;
            end else if (hdr_cnt == 4'd13) begin
              // dst_mac has been stable since the sixth header byte
              if (dst_ok) begin
                state     <= ST_PAYLOAD;
                hdr_valid <= 1'b1;
              end else begin
                state      <= ST_DROP;
                drop_quiet <= 1'b1;
              end
            end
          end
          ST_PAYLOAD: begin
            crc     <= crc_next;
            len_cnt <= len_next;
            dly_buf <= {dly_buf[23:0], in_axis_tdata};
            if (dly_cnt != 3'd4) dly_cnt <= dly_cnt + 3'd1;
            if (in_axis_tlast) begin
              state   <= ST_PREAMBLE;
              dly_cnt <= '0;
              if (dly_cnt == 3'd4) begin
                stat_good    <= !frame_bad;
                stat_crc_err <= frame_bad;
              end else begin
                stat_crc_err <= 1'b1;
              end
            end
          end
          ST_DROP: begin
            if (in_axis_tlast) begin
              state        <= ST_PREAMBLE;
              stat_fmt_err <= !drop_quiet;
              drop_quiet   <= 1'b0;
            end
          end
          default: state <= ST_PREAMBLE;
        endcase
      end
    end
  end

endmodule
